// File: rtl/sram_port_arbiter_if.sv
// Bundle of the fetch-side, data-side and shared-memory-port signals seen by
// the instruction/data arbiter. The arbiter uses the slave view; whatever
// drives requests and models the memory uses the master view.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch side (read only)
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  // EX-stage load/store side
  logic              data_req;
  logic              data_wr;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  // Shared memory port
  logic              mem_req;
  logic              mem_wr;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter putting the fetch side and the load/store side onto one
// SRAM-like memory port. One transaction is outstanding at a time; a new
// request may be accepted in the same cycle the current response returns, so
// back-to-back traffic runs at one transaction every two cycles.
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  sram_port_arbiter_if.slave bus_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_q;
  logic              owner_q;       // 0 = fetch side, 1 = data side
  logic              last_grant_q;  // side granted most recently
  logic              wr_q;
  logic [3:0]        wstrb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic resp_ok;     // response for the outstanding transaction this cycle
  logic accept_win;  // a new request may be taken this cycle
  logic grant_data;
  logic grant_inst;

  // Acceptance window and round-robin choice; on a tie the side that did not
  // win last time gets the port.
  always_comb begin
    resp_ok    = (state_q == WAIT) && bus_if.mem_data_ok;
    accept_win = (state_q == IDLE) || resp_ok;
    grant_data = accept_win && bus_if.data_req &&
                 (!bus_if.inst_req || !last_grant_q);
    grant_inst = accept_win && bus_if.inst_req && !grant_data;
  end

  assign bus_if.inst_addr_ok = grant_inst;
  assign bus_if.data_addr_ok = grant_data;

  // The response is steered to whichever side owns the outstanding request.
  assign bus_if.inst_data_ok = resp_ok && !owner_q;
  assign bus_if.data_data_ok = resp_ok &&  owner_q;
  assign bus_if.inst_rdata   = bus_if.mem_rdata;
  assign bus_if.data_rdata   = bus_if.mem_rdata;

  // Request fields come straight from the latches so they stay stable while
  // the memory port stalls mem_addr_ok.
  assign bus_if.mem_req   = (state_q == REQ);
  assign bus_if.mem_wr    = wr_q;
  assign bus_if.mem_wstrb = wstrb_q;
  assign bus_if.mem_addr  = addr_q;
  assign bus_if.mem_wdata = wdata_q;

  // Transaction FSM: latch the winner, present it until accepted, then wait
  // for its response while watching for the next request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      wr_q         <= 1'b0;
      wstrb_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE, WAIT: begin
          if (grant_data || grant_inst) begin
            state_q      <= REQ;
            owner_q      <= grant_data;
            last_grant_q <= grant_data;
            wr_q         <= grant_data && bus_if.data_wr;
            wstrb_q      <= grant_data ? bus_if.data_wstrb : 4'b0000;
            addr_q       <= grant_data ? bus_if.data_addr  : bus_if.inst_addr;
            wdata_q      <= grant_data ? bus_if.data_wdata : '0;
          end else if (accept_win) begin
            state_q <= IDLE;
          end
        end
        REQ: begin
          // A response arriving here is a protocol violation and is ignored.
          if (bus_if.mem_addr_ok) begin
            state_q <= WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_sram_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction record.
  bit          m_busy;   // a transaction has been granted and not answered
  bit          m_sent;   // memory port has taken the request
  bit          m_side;   // 1 = data side owns it
  bit          m_last;   // side granted most recently
  bit          m_wr;
  logic [3:0]  m_wstrb;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  bit e_i, e_d, e_resp, e_mreq;
  int cyc_no;
  int g_side[$];
  int g_cyc[$];
  int dd_cyc[$];

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check every output against the model at the falling edge,
  // advance the model at the rising edge, then release accepted requests.
  task automatic cycle();
    bit win, any, winner, e_idok, e_ddok;
    @(negedge clk);
    e_resp = m_busy && m_sent && bus.mem_data_ok;
    win    = !m_busy || e_resp;
    any    = bus.inst_req || bus.data_req;
    if (bus.inst_req && bus.data_req) winner = !m_last;
    else                              winner = bus.data_req;
    e_d    = win && any && winner;
    e_i    = win && any && !winner;
    e_idok = e_resp && !m_side;
    e_ddok = e_resp && m_side;
    e_mreq = m_busy && !m_sent;

    chk1("inst_addr_ok", bus.inst_addr_ok, e_i);
    chk1("data_addr_ok", bus.data_addr_ok, e_d);
    chk1("inst_data_ok", bus.inst_data_ok, e_idok);
    chk1("data_data_ok", bus.data_data_ok, e_ddok);
    chk1("mem_req", bus.mem_req, e_mreq);
    if (e_mreq) begin
      chk32("mem_addr", bus.mem_addr, m_addr);
      chk1("mem_wr", bus.mem_wr, m_wr);
      chk32("mem_wstrb", 32'(bus.mem_wstrb), 32'(m_wstrb));
      chk32("mem_wdata", bus.mem_wdata, m_wdata);
    end
    if (e_ddok) chk32("data_rdata", bus.data_rdata, bus.mem_rdata);
    if (e_idok) chk32("inst_rdata", bus.inst_rdata, bus.mem_rdata);
    if (e_resp)
      $display("txn cycle=%0d side=%s addr=%h wr=%0d rdata=%h",
               cyc_no, m_side ? "data" : "inst", m_addr, m_wr, bus.mem_rdata);
    if (e_d || e_i) begin
      g_side.push_back(int'(e_d));
      g_cyc.push_back(cyc_no);
    end
    if (e_ddok) dd_cyc.push_back(cyc_no);

    @(posedge clk);
    if (e_d || e_i) begin
      m_busy = 1'b1;
      m_sent = 1'b0;
      m_side = e_d;
      m_last = e_d;
      m_addr = e_d ? bus.data_addr : bus.inst_addr;
      m_wr   = e_d ? bus.data_wr : 1'b0;
      m_wstrb = e_d ? bus.data_wstrb : 4'b0000;
      m_wdata = e_d ? bus.data_wdata : '0;
    end else if (e_resp) begin
      m_busy = 1'b0;
    end else if (e_mreq && bus.mem_addr_ok) begin
      m_sent = 1'b1;
    end
    cyc_no++;
    #1;
    if (e_i) bus.inst_req = 1'b0;
    if (e_d) bus.data_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.inst_req    = 1'b0;
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    @(posedge clk);
    m_busy = 1'b0; m_sent = 1'b0; m_side = 1'b0; m_last = 1'b0;
    m_wr = 1'b0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
    #1;
    reset = 1'b0;
  endtask

  // Run with a zero-wait memory until nothing is pending, within a bound.
  task automatic drain();
    bus.mem_addr_ok = 1'b1;
    bus.mem_data_ok = 1'b1;
    for (int n = 0; n < 50 && (m_busy || bus.inst_req || bus.data_req); n++) cycle();
    checks++;
    if (m_busy || bus.inst_req || bus.data_req) begin
      errors++;
      $error("FAIL drain_timeout observed=busy expected=idle");
    end
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
  endtask

  initial begin
    bus.inst_req = 1'b0; bus.inst_addr = '0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_wstrb = '0;
    bus.data_addr = '0; bus.data_wdata = '0;
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;
    cyc_no = 0;

    // Reset state
    do_reset();
    chk1("rst_mem_req", bus.mem_req, 1'b0);
    chk32("rst_mem_addr", bus.mem_addr, 32'h0);
    chk32("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk1("rst_inst_data_ok", bus.inst_data_ok, 1'b0);
    chk1("rst_data_data_ok", bus.data_data_ok, 1'b0);
    chk1("rst_data_addr_ok", bus.data_addr_ok, 1'b0);
    cycle();

    // Single load, zero-wait memory
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h1C000010; #1;
    chk1("load_addr_ok", bus.data_addr_ok, 1'b1);
    cycle();
    bus.mem_addr_ok = 1'b1; #1;
    chk1("load_mem_req", bus.mem_req, 1'b1);
    chk32("load_mem_addr", bus.mem_addr, 32'h1C000010);
    cycle();
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hDEADBEEF; #1;
    chk1("load_data_ok", bus.data_data_ok, 1'b1);
    chk32("load_rdata", bus.data_rdata, 32'hDEADBEEF);
    chk1("load_inst_quiet", bus.inst_data_ok, 1'b0);
    cycle();
    bus.mem_data_ok = 1'b0;

    // Both sides held after reset: grants alternate data, inst, data, inst
    do_reset();
    g_side.delete(); g_cyc.delete(); dd_cyc.delete(); cyc_no = 0;
    bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (!bus.inst_req) begin bus.inst_req = 1'b1; bus.inst_addr = 32'h1C000100 + 32'(k * 4); end
      if (!bus.data_req) begin
        bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h1C001000 + 32'(k * 4);
      end
      cycle();
    end
    drain();
    chk32("rr_grant_count_min", 32'(g_side.size() >= 4), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk32("rr_grant_side", 32'(g_side[k]), 32'((k % 2) == 0));
      chk32("rr_grant_cycle", 32'(g_cyc[k]), 32'(2 * k));
    end
    chk32("rr_first_data_ok_cycle", 32'(dd_cyc[0]), 32'd2);

    // Store with strobe, three-cycle mem_addr_ok delay
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'b0011;
    bus.data_wdata = 32'h12345678; bus.data_addr = 32'h1C000200;
    cycle();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1("st_mem_req", bus.mem_req, 1'b1);
      chk1("st_mem_wr", bus.mem_wr, 1'b1);
      chk32("st_mem_wstrb", 32'(bus.mem_wstrb), 32'h3);
      chk32("st_mem_wdata", bus.mem_wdata, 32'h12345678);
      cycle();
    end
    bus.mem_addr_ok = 1'b1;
    cycle();
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1; #1;
    chk1("st_data_ok", bus.data_data_ok, 1'b1);
    chk1("st_inst_quiet", bus.inst_data_ok, 1'b0);
    cycle();
    bus.mem_data_ok = 1'b0;

    // Fetch with a five-cycle response stall; data request waits for it
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1C000300;
    cycle();
    bus.mem_addr_ok = 1'b1;
    cycle();
    bus.mem_addr_ok = 1'b0;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h1C000400;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk1("stall_data_addr_ok", bus.data_addr_ok, 1'b0);
      cycle();
    end
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hCAFEF00D; #1;
    chk1("stall_inst_data_ok", bus.inst_data_ok, 1'b1);
    chk32("stall_inst_rdata", bus.inst_rdata, 32'hCAFEF00D);
    chk1("stall_data_addr_ok_rise", bus.data_addr_ok, 1'b1);
    cycle();
    drain();

    // Reset while waiting for a load response, then a stray response
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h1C000500;
    cycle();
    bus.mem_addr_ok = 1'b1;
    cycle();
    bus.mem_addr_ok = 1'b0;
    do_reset();
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0BADF00D; #1;
    chk1("rst_stray_data_ok", bus.data_data_ok, 1'b0);
    chk1("rst_stray_inst_ok", bus.inst_data_ok, 1'b0);
    cycle();
    bus.mem_data_ok = 1'b0;
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1C000600;
    bus.data_req = 1'b1; bus.data_addr = 32'h1C000700; #1;
    chk1("rst_tie_data_wins", bus.data_addr_ok, 1'b1);
    chk1("rst_tie_inst_loses", bus.inst_addr_ok, 1'b0);
    cycle();

    // Random traffic, stray responses and occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if (!bus.inst_req && $urandom_range(0, 2) == 0) begin
        bus.inst_req = 1'b1; bus.inst_addr = $urandom;
      end
      if (!bus.data_req && $urandom_range(0, 2) == 0) begin
        bus.data_req = 1'b1; bus.data_wr = 1'($urandom_range(0, 1));
        bus.data_wstrb = 4'($urandom); bus.data_addr = $urandom; bus.data_wdata = $urandom;
      end
      bus.mem_addr_ok = 1'($urandom_range(0, 1));
      bus.mem_data_ok = ($urandom_range(0, 2) != 0);
      bus.mem_rdata   = $urandom;
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Arbitrates the CPU's instruction-fetch side and data-access side (EX-stage load/store) onto a single shared SRAM-like memory port. It accepts one request at a time, tracks the single outstanding transaction with a 3-state FSM, and routes the response back to the side that issued it. It sits between the pipeline's fetch/EX stages and the unified memory bus, and uses round-robin arbitration so neither side starves.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request (read only)
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch read data valid this cycle
- inst_rdata  out  DATA_W  fetch read data
- data_req  in  1  load/store request
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  4  byte write strobes (stores)
- data_addr  in  ADDR_W  access address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data valid / store complete this cycle
- data_rdata  out  DATA_W  load data
- mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata  out  1/1/4/ADDR_W/DATA_W  shared-port request fields
- mem_addr_ok  in  1  shared port accepted request
- mem_data_ok  in  1  shared port response valid
- mem_rdata  in  DATA_W  shared port read data

## Operation
- FSM states: IDLE, REQ, WAIT. Registers: state, owner (0 = inst, 1 = data), last_grant, and latched wr/wstrb/addr/wdata.
- Acceptance window: in IDLE, or in WAIT during the cycle mem_data_ok=1.
- Inside the acceptance window, with at least one request pending:
  - Only one side requesting: that side wins.
  - Both sides requesting: the side not equal to last_grant wins.
  - Winner's addr_ok = 1, combinational, in that cycle; the loser's addr_ok = 0.
  - Latch the winner's fields (inst side latches wr=0, wstrb=0, wdata=0); owner and last_grant <= winner; next state REQ.
- Acceptance window with no request pending: next state IDLE.
- REQ: mem_req=1 with the latched fields, held stable until mem_addr_ok. On mem_addr_ok, go to WAIT. mem_data_ok arriving in REQ is a protocol violation and is ignored.
- WAIT: mem_req=0. On mem_data_ok:
  - owner's data_ok = 1 for exactly that cycle.
  - owner's rdata = mem_rdata, combinational pass-through.
  - The new-acceptance rule above applies in the same cycle.
- Upstream handshake: requester holds req and fields until its addr_ok; the arbiter never asserts both addr_ok signals in one cycle.
- mem_data_ok while IDLE: ignored; no data_ok is raised.
- Outputs are 0 whenever not asserted per the rules above; rdata outputs are don't-care when data_ok = 0.

## Timing
- Reset:
  - state=IDLE, last_grant=inst, owner=inst, latched fields=0.
  - mem_req=0; all addr_ok and data_ok outputs = 0.
  - After reset, the first tie goes to data.
- Reset mid-transaction: the FSM returns to IDLE and the outstanding response is dropped. A later stray mem_data_ok is ignored.
- Minimum latency with zero-wait memory:
  - cycle 0: addr_ok
  - cycle 1: mem_req + mem_addr_ok
  - cycle 2: mem_data_ok -> data_ok
- Back-to-back throughput: one transaction per 2 cycles, because the next acceptance overlaps the data_ok cycle.
- mem_addr_ok stalls extend REQ indefinitely; mem_data_ok stalls extend WAIT indefinitely. Neither upstream side is accepted during these stalls.

## Test plan
- Single load:
  - Stimulus: data_req=1, wr=0, addr=0x1C000010; mem_addr_ok=1 immediately; mem_data_ok with rdata=0xDEADBEEF the next cycle.
  - Response: data_addr_ok at cycle 0; mem_req with addr 0x1C000010 at cycle 1; data_data_ok with data_rdata=0xDEADBEEF at cycle 2; inst_data_ok stays 0.
- Simultaneous requests after reset, both held:
  - Grant order: data, inst, data, inst.
  - The second grant coincides with the first response's data_data_ok cycle.
- Store with strobe:
  - Stimulus: wr=1, wstrb=4'b0011, wdata=0x12345678, 3-cycle mem_addr_ok delay.
  - Response: mem_req and all fields held constant for 3 cycles; data_data_ok on mem_data_ok; inst side untouched.
- Fetch stall:
  - Stimulus: inst_req with mem_data_ok delayed 5 cycles; data_req asserted during the wait.
  - Response: data_addr_ok stays 0 until the cycle inst_data_ok=1, then rises in that same cycle.
- Reset during WAIT:
  - Stimulus: reset asserted during WAIT, then a stray mem_data_ok.
  - Response: no data_ok on either side; the next request is accepted normally from IDLE, and data wins a tie.
